// File: rtl/zxuno_regport_fifo_pkg.sv
// Shared constants for the ZX-Uno byte-stream register port: default register
// numbers plus STATUS and CONTROL bit positions.
package zxuno_regport_fifo_pkg;

  localparam logic [7:0] DATAREG_DEF = 8'hC6;
  localparam logic [7:0] STATREG_DEF = 8'hC7;

  localparam int unsigned ST_RXNE   = 7;
  localparam int unsigned ST_TXFULL = 6;
  localparam int unsigned ST_TXOVF  = 5;

  localparam int unsigned CT_FLRX  = 0;
  localparam int unsigned CT_FLTX  = 1;
  localparam int unsigned CT_IRQEN = 7;

  // STATUS only has five bits for the RX count; larger FIFOs saturate.
  function automatic logic [4:0] sat_count5(input logic [31:0] n);
    return (n > 32'd31) ? 5'd31 : n[4:0];
  endfunction

endpackage

// File: rtl/zxuno_sync_fifo.sv
// Single-clock FIFO with push/pop/flush. Full/empty are judged on the
// pre-cycle count, and flush overrides any simultaneous push or pop.
module zxuno_sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full    = count_q[DEPTH_LOG2];
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/zxuno_regport_fifo.sv
// ZX-Uno DATA/STATUS register port in front of TX/RX byte FIFOs.
// Optional feature: define ZXUNO_REGPORT_IRQ_EN for the irq output and irq_en bit.
module zxuno_regport_fifo
  import zxuno_regport_fifo_pkg::*;
#(
  parameter logic [7:0]  DATAREG    = DATAREG_DEF,
  parameter logic [7:0]  STATREG    = STATREG_DEF,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
`ifdef ZXUNO_REGPORT_IRQ_EN
  ,
  output logic       irq
`endif
);

  logic regwr_q, regwr_d, regrd_q, regrd_d;
  logic rd_data_q, rd_data_d, rd_stat_q, rd_stat_d;
  logic txovf_q, txovf_d;
  logic sel_data, sel_stat, wr_ev, rd_end, data_wr, ctrl_wr, rx_pop;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [DEPTH_LOG2:0] tx_count, rx_count;
  logic [7:0] rx_head, status;

  assign sel_data = (zxuno_addr == DATAREG);
  assign sel_stat = (zxuno_addr == STATREG);
  assign wr_ev    = zxuno_regwr & ~regwr_q;
  assign rd_end   = ~zxuno_regrd & regrd_q;
  assign data_wr  = wr_ev & sel_data;
  assign ctrl_wr  = wr_ev & sel_stat;
  assign rx_pop   = rd_end & rd_data_q;
  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

  zxuno_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_wr),
    .din   (din),
    .pop   (tx_ready),
    .flush (ctrl_wr & din[CT_FLTX]),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  zxuno_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (rx_pop),
    .flush (ctrl_wr & din[CT_FLRX]),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // The address may move before the strobe drops, so what the read was
  // (data with RX non-empty, or status) is latched while regrd is high.
  always_comb begin
    regwr_d   = zxuno_regwr;
    regrd_d   = zxuno_regrd;
    rd_data_d = rd_data_q;
    rd_stat_d = rd_stat_q;
    if (rd_end) begin
      rd_data_d = 1'b0;
      rd_stat_d = 1'b0;
    end else if (zxuno_regrd) begin
      if (sel_data & ~rx_empty) rd_data_d = 1'b1;
      if (sel_stat)             rd_stat_d = 1'b1;
    end
    txovf_d = txovf_q;
    if (data_wr & tx_full)      txovf_d = 1'b1;
    else if (rd_end & rd_stat_q) txovf_d = 1'b0;
  end

  always_comb begin
    status            = '0;
    status[ST_RXNE]   = ~rx_empty;
    status[ST_TXFULL] = tx_count[DEPTH_LOG2];
    status[ST_TXOVF]  = txovf_q;
    status[4:0]       = sat_count5(32'(rx_count));
    oe   = zxuno_regrd & (sel_data | sel_stat);
    dout = '1;
    if (zxuno_regrd & sel_data)      dout = rx_empty ? 8'h00 : rx_head;
    else if (zxuno_regrd & sel_stat) dout = status;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwr_q   <= 1'b1;
      regrd_q   <= 1'b1;
      rd_data_q <= 1'b0;
      rd_stat_q <= 1'b0;
      txovf_q   <= 1'b0;
    end else begin
      regwr_q   <= regwr_d;
      regrd_q   <= regrd_d;
      rd_data_q <= rd_data_d;
      rd_stat_q <= rd_stat_d;
      txovf_q   <= txovf_d;
    end
  end

`ifdef ZXUNO_REGPORT_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;

  always_comb begin
    irq_en_d = ctrl_wr ? din[CT_IRQEN] : irq_en_q;
    irq_d    = irq_en_q & ~rx_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_zxuno_regport_fifo.sv
// Bench for zxuno_regport_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations. Honours ZXUNO_REGPORT_IRQ_EN.
module tb_zxuno_regport_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] zxuno_addr = 8'h00;
  logic       zxuno_regrd = 1'b0;
  logic       zxuno_regwr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
`ifdef ZXUNO_REGPORT_IRQ_EN
  logic       irq;
`endif

  int n_chk = 0;
  int n_fail = 0;

  zxuno_regport_fifo #(.DATAREG(8'hC6), .STATREG(8'hC7), .DEPTH_LOG2(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .zxuno_addr  (zxuno_addr),
    .zxuno_regrd (zxuno_regrd),
    .zxuno_regwr (zxuno_regwr),
    .din         (din),
    .dout        (dout),
    .oe          (oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
`ifdef ZXUNO_REGPORT_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two byte queues plus the read/write bookkeeping.
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic prev_wr, prev_rd, m_rd_data, m_rd_stat, m_txovf, m_irq_en, m_irq;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      txq.delete(); rxq.delete();
      prev_wr = 1'b1; prev_rd = 1'b1;
      m_rd_data = 1'b0; m_rd_stat = 1'b0; m_txovf = 1'b0;
      m_irq_en = 1'b0; m_irq = 1'b0;
    end else begin
      logic wev, rend, dwr, cwr, txf, rxf, do_pop, rx_ne;
      wev  = zxuno_regwr && !prev_wr;
      rend = !zxuno_regrd && prev_rd;
      dwr  = wev && zxuno_addr == 8'hC6;
      cwr  = wev && zxuno_addr == 8'hC7;
      txf  = txq.size() == 16;
      rxf  = rxq.size() == 16;
      rx_ne = rxq.size() > 0;
      do_pop = rend && m_rd_data;
      if (dwr && txf) m_txovf = 1'b1;
      else if (rend && m_rd_stat) m_txovf = 1'b0;
      if (rend) begin
        m_rd_data = 1'b0; m_rd_stat = 1'b0;
      end else if (zxuno_regrd) begin
        if (zxuno_addr == 8'hC6 && rx_ne) m_rd_data = 1'b1;
        if (zxuno_addr == 8'hC7) m_rd_stat = 1'b1;
      end
      if (cwr && din[1]) txq.delete();
      else begin
        if (tx_ready && txq.size() > 0) void'(txq.pop_front());
        if (dwr && !txf) txq.push_back(din);
      end
      if (cwr && din[0]) rxq.delete();
      else begin
        if (do_pop && rxq.size() > 0) void'(rxq.pop_front());
        if (rx_valid && !rxf) rxq.push_back(rx_data);
      end
      m_irq = m_irq_en && rx_ne;
      if (cwr) m_irq_en = din[7];
      prev_wr = zxuno_regwr;
      prev_rd = zxuno_regrd;
    end
  end

  always @(negedge clk) begin
    logic [7:0] e_dout, e_stat;
    logic e_oe;
    e_stat = {rxq.size() > 0, txq.size() == 16, m_txovf, 5'(rxq.size())};
    e_oe = zxuno_regrd && (zxuno_addr == 8'hC6 || zxuno_addr == 8'hC7);
    e_dout = 8'hFF;
    if (zxuno_regrd && zxuno_addr == 8'hC6) e_dout = (rxq.size() > 0) ? rxq[0] : 8'h00;
    else if (zxuno_regrd && zxuno_addr == 8'hC7) e_dout = e_stat;
    chk("m_oe", {7'b0, oe}, {7'b0, e_oe});
    chk("m_dout", dout, e_dout);
    chk("m_tx_valid", {7'b0, tx_valid}, {7'b0, txq.size() > 0});
    if (txq.size() > 0) chk("m_tx_data", tx_data, txq[0]);
    chk("m_rx_ready", {7'b0, rx_ready}, {7'b0, rxq.size() < 16});
`ifdef ZXUNO_REGPORT_IRQ_EN
    chk("m_irq", {7'b0, irq}, {7'b0, m_irq});
`endif
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input int hold);
    zxuno_addr = a; din = d; zxuno_regwr = 1'b1;
    cyc(hold);
    zxuno_regwr = 1'b0;
    cyc(1);
  endtask

  task automatic rd(input logic [7:0] a, input int hold, output logic [7:0] first, output logic stable);
    logic [7:0] v;
    zxuno_addr = a; zxuno_regrd = 1'b1; stable = 1'b1; first = 8'hXX;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      v = dout;
      if (i == 0) first = v;
      else if (v !== first) stable = 1'b0;
      @(posedge clk); #1;
    end
    zxuno_regrd = 1'b0;
    cyc(1);
  endtask

  initial begin
    logic [7:0] v;
    logic st;
    #1 rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);

    // 1: reset state
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    chk("rst_oe", {7'b0, oe}, 8'h00);
    chk("rst_dout", dout, 8'hFF);
    rd(8'hC7, 1, v, st);
    chk("rst_status", v, 8'h00);

    // 2: long write strobe pushes once
    wr(8'hC6, 8'hA5, 20);
    chk("wr_tx_valid", {7'b0, tx_valid}, 8'h01);
    chk("wr_tx_data", tx_data, 8'hA5);
    tx_ready = 1'b1; cyc(1); tx_ready = 1'b0;
    chk("wr_one_entry", {7'b0, tx_valid}, 8'h00);

    // 3: overflow, TXOVF clear on status read, drain order
    for (int i = 0; i < 17; i++) wr(8'hC6, 8'(i), 2);
    rd(8'hC7, 1, v, st);
    chk("ovf_status", v, 8'h60);
    rd(8'hC7, 1, v, st);
    chk("ovf_cleared", v, 8'h40);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("drain_data", tx_data, 8'(i));
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    chk("drain_empty", {7'b0, tx_valid}, 8'h00);
    rd(8'hC7, 1, v, st);
    chk("drain_status", v, 8'h00);

    // 4: RX reads pop at end of strobe
    rx_valid = 1'b1; rx_data = 8'h3C; cyc(1);
    rx_data = 8'h7E; cyc(1);
    rx_valid = 1'b0;
    rd(8'hC6, 10, v, st);
    chk("rd1_data", v, 8'h3C);
    chk("rd1_stable", {7'b0, st}, 8'h01);
    rd(8'hC6, 3, v, st);
    chk("rd2_data", v, 8'h7E);
    rd(8'hC6, 3, v, st);
    chk("rd3_empty", v, 8'h00);
    rd(8'hC7, 1, v, st);
    chk("rd_status0", v, 8'h00);

    // 5: RX full, rx_valid during pop rejected, flush
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(16 + i); cyc(1);
    end
    rx_valid = 1'b0;
    chk("rxfull_ready", {7'b0, rx_ready}, 8'h00);
    rd(8'hC7, 1, v, st);
    chk("rxfull_status", v, 8'h90);
    zxuno_addr = 8'hC6; zxuno_regrd = 1'b1; cyc(2);
    rx_valid = 1'b1; rx_data = 8'hEE; zxuno_regrd = 1'b0; cyc(1);
    rx_valid = 1'b0;
    rd(8'hC7, 1, v, st);
    chk("pop_rej_status", v, 8'h8F);
    rd(8'hC6, 1, v, st);
    chk("pop_head", v, 8'h11);
    wr(8'hC7, 8'h01, 2);
    rd(8'hC7, 1, v, st);
    chk("flush_status", v, 8'h00);
    chk("flush_ready", {7'b0, rx_ready}, 8'h01);

    // 6: reset during a held write strobe
    zxuno_addr = 8'hC6; din = 8'h55; zxuno_regwr = 1'b1;
    cyc(2);
    rst = 1'b1; cyc(2);
    rst = 1'b0; cyc(3);
    zxuno_regwr = 1'b0; cyc(1);
    chk("rst_wr_nopush", {7'b0, tx_valid}, 8'h00);

`ifdef ZXUNO_REGPORT_IRQ_EN
    wr(8'hC7, 8'h80, 2);
    rx_valid = 1'b1; rx_data = 8'h5A; cyc(1);
    rx_valid = 1'b0;
    chk("irq_lag", {7'b0, irq}, 8'h00);
    cyc(1);
    chk("irq_set", {7'b0, irq}, 8'h01);
    rd(8'hC6, 2, v, st);
    chk("irq_data", v, 8'h5A);
    cyc(1);
    chk("irq_clr", {7'b0, irq}, 8'h00);
    wr(8'hC7, 8'h00, 2);
`endif

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
